imul_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one iterative integer multiplier (64-bit {a,b} request in, 32-bit product out, val/rdy on both sides) among NREQ requesters.
- Exactly one operation is in flight at a time. The arbiter records which requester owns it and steers the product back to that requester only.
- Sits between the processor-side requester ports and a single multiplier instance.
- Exports owner, busy and an operation counter for line tracing and performance counting.

---
 rtl/imul_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_imul_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imul_rr_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among NREQ requesters.
// One operation in flight; the owner index steers the product back to its requester.
module imul_rr_arbiter #(
   parameter  int unsigned NREQ  = 4,
   parameter  int unsigned NBITS = 32,
   localparam int unsigned GW    = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NREQ-1:0]         req_val,
   output logic [NREQ-1:0]         req_rdy,
   input  logic [NREQ*2*NBITS-1:0] req_msg,
   output logic [NREQ-1:0]         resp_val,
   input  logic [NREQ-1:0]         resp_rdy,
   output logic [NBITS-1:0]        resp_msg,
   output logic                    mul_istream_val,
   input  logic                    mul_istream_rdy,
   output logic [2*NBITS-1:0]      mul_istream_msg,
   input  logic                    mul_ostream_val,
   output logic                    mul_ostream_rdy,
   input  logic [NBITS-1:0]        mul_ostream_msg,
   output logic [GW-1:0]           owner,
   output logic                    busy,
   output logic [31:0]             op_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state;
   state_t            state_next;
   logic [GW-1:0]     rr_ptr;
   logic [GW-1:0]     rr_next;
   logic [GW-1:0]     grant_idx;
   logic [GW-1:0]     scan_idx;
   logic              grant_any;
   logic              issue_fire;
   logic              resp_fire;
   logic [2*NBITS-1:0] req_msg_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_msg
      assign req_msg_arr[g] = req_msg[g*2*NBITS +: 2*NBITS];
   end

   // First valid requester scanning upward from rr_ptr, wrapping at NREQ.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         scan_idx = GW'((32'(rr_ptr) + i) % NREQ);
         if (!grant_any && req_val[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   assign issue_fire = (state == ISSUE) && mul_istream_rdy;
   assign resp_fire  = (state == WAIT) && mul_ostream_val && resp_rdy[owner];
   assign rr_next    = (owner == GW'(NREQ - 1)) ? '0 : owner + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (grant_any)  state_next = ISSUE;
         ISSUE:   if (issue_fire) state_next = WAIT;
         WAIT:    if (resp_fire)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner    <= '0;
         rr_ptr   <= '0;
         op_count <= '0;
      end else begin
         if (state == IDLE && grant_any) begin
            owner <= grant_idx;
         end
         if (resp_fire) begin
            rr_ptr   <= rr_next;
            op_count <= op_count + 32'd1;
         end
      end
   end

   always_comb begin
      req_rdy         = '0;
      resp_val        = '0;
      resp_msg        = '0;
      mul_istream_val = 1'b0;
      mul_istream_msg = '0;
      mul_ostream_rdy = 1'b0;
      busy            = 1'b0;
      unique case (state)
         ISSUE: begin
            busy            = 1'b1;
            mul_istream_val = 1'b1;
            mul_istream_msg = req_msg_arr[owner];
            req_rdy[owner]  = mul_istream_rdy;
         end
         WAIT: begin
            busy            = 1'b1;
            mul_ostream_rdy = resp_rdy[owner];
            resp_val[owner] = mul_ostream_val;
            resp_msg        = mul_ostream_msg;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_imul_rr_arbiter.sv
// Directed bench for imul_rr_arbiter with a small fixed-latency multiplier model.
module tb_imul_rr_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned NBITS = 32;
   localparam int unsigned GW    = $clog2(NREQ);

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic [NREQ-1:0]         req_val = '0;
   logic [NREQ-1:0]         req_rdy;
   logic [NREQ*2*NBITS-1:0] req_msg = '0;
   logic [NREQ-1:0]         resp_val;
   logic [NREQ-1:0]         resp_rdy = '1;
   logic [NBITS-1:0]        resp_msg;
   logic                    mul_istream_val;
   logic                    mul_istream_rdy;
   logic [2*NBITS-1:0]      mul_istream_msg;
   logic                    mul_ostream_val;
   logic                    mul_ostream_rdy;
   logic [NBITS-1:0]        mul_ostream_msg;
   logic [GW-1:0]           owner;
   logic                    busy;
   logic [31:0]             op_count;

   int checks = 0;
   int errors = 0;

   imul_rr_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
      .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
      .mul_istream_val(mul_istream_val), .mul_istream_rdy(mul_istream_rdy),
      .mul_istream_msg(mul_istream_msg),
      .mul_ostream_val(mul_ostream_val), .mul_ostream_rdy(mul_ostream_rdy),
      .mul_ostream_msg(mul_ostream_msg),
      .owner(owner), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Multiplier model: accepts when idle, result ready a few cycles later.
   logic             m_busy;
   logic             m_done;
   logic [2:0]       m_cnt;
   logic [NBITS-1:0] m_res;
   logic             stall = 1'b0;

   assign mul_istream_rdy = !m_busy && !stall;
   assign mul_ostream_val = m_done;
   assign mul_ostream_msg = m_res;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_cnt  <= '0;
         m_res  <= '0;
      end else if (mul_istream_val && mul_istream_rdy) begin
         m_busy <= 1'b1;
         m_cnt  <= 3'd3;
         m_res  <= mul_istream_msg[2*NBITS-1:NBITS] * mul_istream_msg[NBITS-1:0];
      end else if (m_busy && !m_done) begin
         if (m_cnt == 3'd0) m_done <= 1'b1;
         else               m_cnt  <= m_cnt - 3'd1;
      end else if (m_done && mul_ostream_rdy) begin
         m_done <= 1'b0;
         m_busy <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_msg(input int idx, input logic [31:0] a, input logic [31:0] b);
      req_msg[idx*2*NBITS +: 2*NBITS] = {a, b};
   endtask

   // Waits for requester idx's request to be accepted, then drops its req_val.
   task automatic wait_accept(input int idx, input string tag);
      bit done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk); #1;
         if (req_val[idx] && req_rdy[idx]) done = 1'b1;
      end
      check({tag, "_accept"}, 64'(done), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_val[idx] = 1'b0;
   endtask

   // Waits for a response handshake; checks target, product, owner and stray resp_val bits.
   task automatic wait_resp(input int exp_idx, input logic [31:0] exp_msg, input string tag);
      logic [NREQ-1:0] seen = '0;
      bit done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk); #1;
         seen |= resp_val;
         if ((resp_val & resp_rdy) != '0) begin
            check({tag, "_resp_val"}, 64'(resp_val), 64'(1 << exp_idx));
            check({tag, "_resp_msg"}, 64'(resp_msg), 64'(exp_msg));
            check({tag, "_owner"},    64'(owner),    64'(exp_idx));
            done = 1'b1;
         end
      end
      check({tag, "_resp_seen"}, 64'(done), 64'd1);
      check({tag, "_stray_val"}, 64'(seen), 64'(1 << exp_idx));
      @(posedge clk); #1;
   endtask

   task automatic wait_ostream_val(input string tag);
      bit done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk); #1;
         if (mul_ostream_val) done = 1'b1;
      end
      check({tag, "_ostream_val"}, 64'(done), 64'd1);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_req_rdy",  64'(req_rdy), 64'd0);
      check("rst_resp_val", 64'(resp_val), 64'd0);
      check("rst_busy",     64'(busy), 64'd0);
      check("rst_istream",  64'(mul_istream_val), 64'd0);
      check("rst_imsg",     64'(mul_istream_msg), 64'd0);
      check("rst_ordy",     64'(mul_ostream_rdy), 64'd0);
      check("rst_owner",    64'(owner), 64'd0);
      check("rst_opcnt",    64'(op_count), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Prime: one completed op on requester 1, then park requester 2 in WAIT
      set_msg(1, 32'd2, 32'd2);
      req_val = 4'b0010;
      wait_accept(1, "prime");
      wait_resp(1, 32'd4, "prime");
      check("prime_opcnt", 64'(op_count), 64'd1);
      set_msg(2, 32'd9, 32'd9);
      resp_rdy = 4'b1011;
      req_val  = 4'b0100;
      wait_accept(2, "park");
      wait_ostream_val("park");
      check("park_busy", 64'(busy), 64'd1);
      check("park_resp_val", 64'(resp_val), 64'h4);

      // Reset mid-WAIT, observed asynchronously before the next clock edge
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_busy",     64'(busy), 64'd0);
      check("midrst_resp_val", 64'(resp_val), 64'd0);
      check("midrst_resp_msg", 64'(resp_msg), 64'd0);
      check("midrst_ordy",     64'(mul_ostream_rdy), 64'd0);
      check("midrst_owner",    64'(owner), 64'd0);
      check("midrst_opcnt",    64'(op_count), 64'd0);
      check("midrst_rrptr",    64'(dut.rr_ptr), 64'd0);
      @(negedge clk);
      reset_n  = 1'b1;
      resp_rdy = 4'b1111;
      set_msg(0, 32'd3, 32'd5);
      req_val = 4'b0001;
      @(posedge clk); #1;
      check("lat_issue", 64'(mul_istream_val), 64'd1);
      check("lat_imsg",  64'(mul_istream_msg), {32'd3, 32'd5});
      wait_accept(0, "post_rst");
      wait_resp(0, 32'd15, "post_rst");
      check("post_rst_opcnt", 64'(op_count), 64'd1);

      // Single requester 2
      set_msg(2, 32'd7, 32'd6);
      req_val = 4'b0100;
      wait_accept(2, "single");
      wait_resp(2, 32'd42, "single");
      check("single_opcnt", 64'(op_count), 64'd2);
      check("single_rrptr", 64'(dut.rr_ptr), 64'd3);
      check("single_idle",  64'(busy), 64'd0);

      // Full contention from a fresh reset: grants rotate 0,1,2,3,0
      pulse_reset();
      for (int i = 0; i < 4; i++) set_msg(i, 32'(i + 1), 32'd10);
      req_val = 4'b1111;
      wait_resp(0, 32'd10, "cont0");
      wait_resp(1, 32'd20, "cont1");
      wait_resp(2, 32'd30, "cont2");
      wait_resp(3, 32'd40, "cont3");
      wait_resp(0, 32'd10, "cont4");
      @(negedge clk);
      req_val = '0;
      check("cont_opcnt", 64'(op_count), 64'd5);
      check("cont_rrptr", 64'(dut.rr_ptr), 64'd1);

      // Round-robin skip: rr_ptr=1, only 0 and 3 requesting
      set_msg(3, 32'd4, 32'd4);
      set_msg(0, 32'd5, 32'd5);
      req_val = 4'b1001;
      wait_accept(3, "skip3");
      wait_resp(3, 32'd16, "skip3");
      wait_accept(0, "skip0");
      wait_resp(0, 32'd25, "skip0");
      check("skip_opcnt", 64'(op_count), 64'd7);

      // Response backpressure on requester 1
      set_msg(1, 32'hFFFF_FFFF, 32'd2);
      resp_rdy = 4'b1101;
      req_val  = 4'b0010;
      wait_accept(1, "bp");
      wait_ostream_val("bp");
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         check("bp_ordy",     64'(mul_ostream_rdy), 64'd0);
         check("bp_busy",     64'(busy), 64'd1);
         check("bp_resp_val", 64'(resp_val), 64'h2);
         check("bp_resp_msg", 64'(resp_msg), 64'hFFFF_FFFE);
      end
      check("bp_opcnt_hold", 64'(op_count), 64'd7);
      @(negedge clk);
      resp_rdy = 4'b1111;
      #1;
      check("bp_release_ordy", 64'(mul_ostream_rdy), 64'd1);
      @(posedge clk); #1;
      check("bp_done_busy",  64'(busy), 64'd0);
      check("bp_done_opcnt", 64'(op_count), 64'd8);
      check("bp_rrptr",      64'(dut.rr_ptr), 64'd2);

      // Multiplier input stall, then a wrapping product
      stall = 1'b1;
      set_msg(2, 32'h0001_0000, 32'h0001_0000);
      req_val = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         if (c > 0) begin
            check("stall_ival", 64'(mul_istream_val), 64'd1);
            check("stall_rdy",  64'(req_rdy), 64'd0);
            check("stall_imsg", 64'(mul_istream_msg), {32'h0001_0000, 32'h0001_0000});
         end
      end
      @(negedge clk);
      stall = 1'b0;
      #1;
      check("stall_release_rdy", 64'(req_rdy), 64'h4);
      @(posedge clk); #1;
      check("stall_to_wait", 64'(mul_istream_val), 64'd0);
      @(negedge clk);
      req_val = '0;
      wait_resp(2, 32'd0, "wrap");
      check("wrap_opcnt", 64'(op_count), 64'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
